// File: rtl/aes_pkg.sv
// Shared AES-128 constants and helpers: widths, round count, rcon table and GF(2^8) arithmetic.
package aes_pkg;

  localparam int STATE_W     = 128;
  localparam int WORD_W      = 32;
  localparam int BYTE_W      = 8;
  localparam int NUM_ROUNDS_DEF = 10;

  // Round constants rcon[1..10]; index 0 is unused and returns 0.
  function automatic logic [7:0] rcon(input logic [3:0] idx);
    logic [7:0] r;
    r = 8'h00;
    case (idx)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Shift-and-add multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

endpackage

// File: rtl/sbox.sv
// AES forward S-box: multiplicative inverse (x^254) in GF(2^8) followed by the affine map.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;
  logic [7:0] b;

  // Addition chain for x^254 = x^240 * x^12 * x^2; zero maps to zero.
  assign x2   = gf_mul(a_i, a_i);
  assign x3   = gf_mul(x2, a_i);
  assign x6   = gf_mul(x3, x3);
  assign x12  = gf_mul(x6, x6);
  assign x15  = gf_mul(x12, x3);
  assign x30  = gf_mul(x15, x15);
  assign x60  = gf_mul(x30, x30);
  assign x120 = gf_mul(x60, x60);
  assign x240 = gf_mul(x120, x120);
  assign x252 = gf_mul(x240, x12);
  assign inv  = gf_mul(x252, x2);

  assign b   = inv;
  assign y_o = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;

endmodule

// File: rtl/add_round_key.sv
// AddRoundKey stage with on-the-fly AES-128 key expansion: one round key per accepted state,
// XORed into the incoming state and registered.
module add_round_key
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               key_load,
  input  logic [STATE_W-1:0] key_in,
  input  logic               in_valid,
  input  logic [STATE_W-1:0] state_in,
  output logic               ready,
  output logic               out_valid,
  output logic [STATE_W-1:0] state_out,
  output logic [3:0]         round,
  output logic               done
);

  localparam logic [3:0] LAST_RC = 4'(NUM_ROUNDS);

  logic [STATE_W-1:0] rk_q, rk_d;
  logic [3:0]         rc_q, rc_d;
  logic               active_q, active_d;
  logic               out_valid_q, out_valid_d;
  logic               done_q, done_d;
  logic [3:0]         round_q, round_d;
  logic [STATE_W-1:0] state_out_q, state_out_d;

  logic               accept;
  logic [WORD_W-1:0]  w0, w1, w2, w3, rot_w3, sub_w3, t;
  logic [WORD_W-1:0]  n0, n1, n2, n3;
  logic [STATE_W-1:0] next_rk;

  // Key expansion for the next round: t = SubWord(RotWord(w3)) ^ {rcon,0,0,0}.
  assign {w0, w1, w2, w3} = rk_q;
  assign rot_w3 = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    sbox u_sbox (
      .a_i (rot_w3[g*BYTE_W +: BYTE_W]),
      .y_o (sub_w3[g*BYTE_W +: BYTE_W])
    );
  end

  assign t       = sub_w3 ^ {rcon(rc_q + 4'd1), 24'h000000};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  assign accept = in_valid && active_q && !key_load;

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rk_d        = rk_q;
    rc_d        = rc_q;
    active_d    = active_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    round_d     = round_q;
    state_out_d = state_out_q;
    if (key_load) begin
      rk_d     = key_in;
      rc_d     = 4'd0;
      active_d = 1'b1;
    end else if (accept) begin
      state_out_d = state_in ^ rk_q;
      out_valid_d = 1'b1;
      round_d     = rc_q;
      if (rc_q < LAST_RC) begin
        rk_d = next_rk;
        rc_d = rc_q + 4'd1;
      end else begin
        done_d   = 1'b1;
        active_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only; reset is synchronous and clears all of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      rk_q        <= '0;
      rc_q        <= '0;
      active_q    <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      round_q     <= '0;
      state_out_q <= '0;
    end else begin
      rk_q        <= rk_d;
      rc_q        <= rc_d;
      active_q    <= active_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      round_q     <= round_d;
      state_out_q <= state_out_d;
    end
  end

  assign ready     = active_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign round     = round_q;
  assign state_out = state_out_q;

endmodule

// File: doc/add_round_key.md
ADD_ROUND_KEY -- requirements
Module: add_round_key

Interface
REQ-001 Parameter: NUM_ROUNDS, default 10, last round index of the AES-128 schedule; only 10 is supported.
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 key_load  input  1  loads the cipher key; single-cycle pulse.
REQ-005 key_in  input  128  cipher key; word 0 is bits 127:96, row-0 byte is the MSB of each word.
REQ-006 in_valid  input  1  state_in carries a state to combine with the current round key.
REQ-007 state_in  input  128  state from the upstream stage (initial plaintext, or mixColumns/shiftRows output), same column-major byte order as mixColumns.
REQ-008 ready  output  1  a key is loaded and rounds remain; in_valid is accepted only when ready=1.
REQ-009 out_valid  output  1  state_out valid; one-cycle pulse per accepted input.
REQ-010 state_out  output  128  state_in XOR current round key, registered.
REQ-011 round  output  4  index of the round key applied to the most recent output.
REQ-012 done  output  1  one-cycle pulse together with the out_valid that used round key NUM_ROUNDS.

Function
REQ-013 The block shall hold a 128-bit round-key register rk and a 4-bit counter rc (0..NUM_ROUNDS), plus a flag meaning "schedule active".
REQ-014 key_load=1 shall set rk<=key_in, rc<=0 and active<=1; out_valid shall stay 0 in that cycle.
REQ-015 An accept occurs when in_valid=1, ready=1 and key_load=0.
REQ-016 ready shall equal active; it is combinational from registers only, with no path from in_valid.
REQ-017 On accept: state_out<=state_in^rk, out_valid<=1 and round<=rc, all on the next edge (latency 1 cycle, throughput 1 per cycle).
REQ-018 On accept with rc<NUM_ROUNDS: rk<=next_key(rk, rcon[rc+1]) and rc<=rc+1.
REQ-019 On accept with rc=NUM_ROUNDS: done<=1, active<=0, and rk and rc shall hold.
REQ-020 next_key, FIPS-197 with words w0..w3 of rk:
- t = SubWord(RotWord(w3)) ^ {rcon,00,00,00}
- w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'
REQ-021 rcon[1..10] shall be 01,02,04,08,10,20,40,80,1b,36.
REQ-022 in_valid while ready=0 shall be ignored: no output and no state change.
REQ-023 If key_load and in_valid are high in the same cycle, key_load shall win and the input shall be dropped.
REQ-024 key_load mid-schedule shall restart at round 0 with the new key; the output of an accept in the previous cycle still appears.
REQ-025 With no accept, out_valid and done shall be 0; state_out and round shall hold their last values.

Reset
REQ-026 rst=1 at a clock edge shall clear rk, rc, active, out_valid, done, round and state_out to 0, so ready=0.
REQ-027 rst shall override key_load and in_valid in the same cycle.
REQ-028 Reset mid-schedule shall abandon the schedule; no further outputs until a new key_load.

Structure
REQ-029 The package aes_pkg shall hold the rcon table, the NUM_ROUNDS default and the 128-bit state/word width constants.
REQ-030 SubWord shall use four instances of the combinational sub-module sbox (byte in, byte out), shared with subBytes.
REQ-031 There shall be no other sub-modules; the key-expansion XOR chain shall be inline, with one register stage for the outputs.

Verification
REQ-032 After reset, key_load with key 2b7e151628aed2a6abf7158809cf4f3c, then in_valid with state_in 3243f6a8885a308d313198a2e0370734 -> next cycle state_out 193de3bea0f4e22b9ac68d2ae9f84808, round=0, out_valid=1.
REQ-033 Second accept with state_in 046681e5e0cb199a48f8d37a2806264c -> state_out a49c7ff2689f352b6b5bea43026a5049, round=1.
REQ-034 Eleven back-to-back accepts with state_in=0 -> the eleventh state_out is d014f9a8c9ee2589e13f0cc8b6630ca6, round=10, done=1, then ready=0; a twelfth in_valid produces no out_valid.
REQ-035 key_load and in_valid in the same cycle, then in_valid -> exactly one out_valid, using round key 0 (state_out=state_in^key_in).
REQ-036 rst asserted after round 4 with in_valid held high -> out_valid=0, ready=0 and all outputs 0 until key_load; after key_load the next output uses round 0.
